// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: character alignment via bitslip requests, then
// decode of control tokens and data characters for one DVI channel.
// Optional build macro: TMDS_ERRCNT_EN enables the illegal-character counter
// (err_count/err_clr); without it err_count is tied to zero.
module tmds_channel_decoder #(
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOCK_RUN      = 8,
  parameter int SLIP_SETTLE   = 16,
  parameter int LOSS_WINDOW   = 4096
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic [9:0]  tmds_word,
  input  logic        err_clr,
  output logic        bitslip,
  output logic        locked,
  output logic        de,
  output logic [1:0]  ctrl,
  output logic [7:0]  data,
  output logic [15:0] err_count
);

  localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int SET_W  = $clog2(SLIP_SETTLE + 1);
  localparam int LOSS_W = $clog2(LOSS_WINDOW + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_RUN - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SLIP_SETTLE - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Undo transition minimisation (q[9] inversion, q[8] XOR/XNOR chain).
  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] x;
    logic [7:0] d;
    x    = q[9] ? ~q[7:0] : q[7:0];
    d[0] = x[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (x[i] ^ x[i-1]) : ~(x[i] ^ x[i-1]);
    end
    return d;
  endfunction

`ifdef TMDS_ERRCNT_EN
  // Encoder picks XNOR (q[8]=0) for many ones, or exactly four with d[0]=0.
  function automatic logic tmds_q8_legal(input logic [9:0] q);
    logic [7:0] d;
    logic [3:0] ones;
    logic       use_xnor;
    d    = tmds_decode(q);
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'd0, d[i]};
    end
    use_xnor = (ones > 4'd4) || ((ones == 4'd4) && (d[0] == 1'b0));
    return (q[8] == ~use_xnor);
  endfunction
`endif

  logic [9:0]        s1_word_r;
  logic              s1_token_r;
  logic [1:0]        s1_tok_ctrl_r;
  logic              tok_s;
  logic [1:0]        tok_ctrl_s;

  state_t            state_r, state_s;
  logic [WIN_W-1:0]  win_r, win_s;
  logic [RUN_W-1:0]  run_r, run_s;
  logic [SET_W-1:0]  settle_r, settle_s;
  logic [LOSS_W-1:0] loss_r, loss_s;
  logic              slip_s;

  logic              bitslip_r, locked_r, de_r;
  logic [1:0]        ctrl_r, ctrl_s;
  logic [7:0]        data_r, data_s;
  logic              de_s;
  logic [15:0]       err_r, err_s;
  logic              in_lock_s;

  // Recognise the four control tokens on the incoming word.
  always_comb begin
    tok_s      = 1'b0;
    tok_ctrl_s = 2'b00;
    case (tmds_word)
      10'h354: begin tok_s = 1'b1; tok_ctrl_s = 2'b00; end
      10'h0AB: begin tok_s = 1'b1; tok_ctrl_s = 2'b01; end
      10'h154: begin tok_s = 1'b1; tok_ctrl_s = 2'b10; end
      10'h2AB: begin tok_s = 1'b1; tok_ctrl_s = 2'b11; end
      default: begin tok_s = 1'b0; tok_ctrl_s = 2'b00; end
    endcase
  end

  // Stage 1: capture the word together with its classification.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      s1_word_r     <= 10'd0;
      s1_token_r    <= 1'b0;
      s1_tok_ctrl_r <= 2'b00;
    end else begin
      s1_word_r     <= tmds_word;
      s1_token_r    <= tok_s;
      s1_tok_ctrl_r <= tok_ctrl_s;
    end
  end

  // Alignment FSM: next state, counters and the bitslip request.
  always_comb begin
    state_s  = state_r;
    win_s    = win_r;
    run_s    = run_r;
    settle_s = settle_r;
    loss_s   = loss_r;
    slip_s   = 1'b0;
    case (state_r)
      ST_SEARCH: begin
        win_s = win_r + WIN_W'(1);
        if (s1_token_r) begin
          run_s = run_r + RUN_W'(1);
        end else begin
          run_s = RUN_W'(0);
        end
        // A completed token run takes priority over an expiring window.
        if (s1_token_r && (run_r == RUN_LAST)) begin
          state_s = ST_LOCKED;
          loss_s  = LOSS_W'(0);
        end else if (win_r == WIN_LAST) begin
          state_s  = ST_SETTLE;
          slip_s   = 1'b1;
          settle_s = SET_W'(0);
        end else begin
          state_s = ST_SEARCH;
        end
      end
      ST_SETTLE: begin
        settle_s = settle_r + SET_W'(1);
        if (settle_r == SET_LAST) begin
          state_s = ST_SEARCH;
          win_s   = WIN_W'(0);
          run_s   = RUN_W'(0);
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_LOCKED: begin
        if (s1_token_r) begin
          loss_s = LOSS_W'(0);
        end else begin
          loss_s = loss_r + LOSS_W'(1);
        end
        if (!s1_token_r && (loss_r == LOSS_LAST)) begin
          state_s = ST_SEARCH;
          win_s   = WIN_W'(0);
          run_s   = RUN_W'(0);
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s  = ST_SEARCH;
        win_s    = WIN_W'(0);
        run_s    = RUN_W'(0);
        settle_s = SET_W'(0);
        loss_s   = LOSS_W'(0);
      end
    endcase
  end

  // Alignment FSM state and counter registers.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_r  <= ST_SEARCH;
      win_r    <= WIN_W'(0);
      run_r    <= RUN_W'(0);
      settle_r <= SET_W'(0);
      loss_r   <= LOSS_W'(0);
    end else begin
      state_r  <= state_s;
      win_r    <= win_s;
      run_r    <= run_s;
      settle_r <= settle_s;
      loss_r   <= loss_s;
    end
  end

  // Stage 2 values: decode only while locked, otherwise force idle outputs.
  always_comb begin
    in_lock_s = (state_r == ST_LOCKED);
    de_s      = 1'b0;
    ctrl_s    = 2'b00;
    data_s    = 8'h00;
    if (!in_lock_s) begin
      de_s   = 1'b0;
      ctrl_s = 2'b00;
      data_s = 8'h00;
    end else if (s1_token_r) begin
      de_s   = 1'b0;
      ctrl_s = s1_tok_ctrl_r;
      data_s = 8'h00;
    end else begin
      de_s   = 1'b1;
      ctrl_s = ctrl_r;
      data_s = tmds_decode(s1_word_r);
    end
  end

`ifdef TMDS_ERRCNT_EN
  // Saturating illegal-character counter; a clear beats a coincident hit.
  always_comb begin
    err_s = err_r;
    if (err_clr) begin
      err_s = 16'h0000;
    end else if (in_lock_s && !s1_token_r && !tmds_q8_legal(s1_word_r) && (err_r != 16'hFFFF)) begin
      err_s = err_r + 16'h0001;
    end else begin
      err_s = err_r;
    end
  end
`else
  logic err_clr_unused_s;
  assign err_clr_unused_s = err_clr;

  // Counter disabled: hold at zero.
  always_comb begin
    err_s = 16'h0000;
  end
`endif

  // Stage 2: registered outputs.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bitslip_r <= 1'b0;
      locked_r  <= 1'b0;
      de_r      <= 1'b0;
      ctrl_r    <= 2'b00;
      data_r    <= 8'h00;
      err_r     <= 16'h0000;
    end else begin
      bitslip_r <= slip_s;
      locked_r  <= (state_s == ST_LOCKED);
      de_r      <= de_s;
      ctrl_r    <= ctrl_s;
      data_r    <= data_s;
      err_r     <= err_s;
    end
  end

  assign bitslip   = bitslip_r;
  assign locked    = locked_r;
  assign de        = de_r;
  assign ctrl      = ctrl_r;
  assign data      = data_r;
  assign err_count = err_r;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder. Honours TMDS_ERRCNT_EN.
module tb_tmds_channel_decoder;

  logic        clk_pixel = 1'b0;
  logic        reset;
  logic [9:0]  tmds_word;
  logic        err_clr;
  logic        bitslip;
  logic        locked;
  logic        de;
  logic [1:0]  ctrl;
  logic [7:0]  data;
  logic [15:0] err_count;

  tmds_channel_decoder dut (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .tmds_word (tmds_word),
    .err_clr   (err_clr),
    .bitslip   (bitslip),
    .locked    (locked),
    .de        (de),
    .ctrl      (ctrl),
    .data      (data),
    .err_count (err_count)
  );

  always #5 clk_pixel = ~clk_pixel;

  int         n_chk  = 0;
  int         n_pass = 0;
  logic       m_chk  = 1'b0;
  logic [9:0] prev_w = 10'd0;
  logic [1:0] m_ctrl = 2'b00;
  int         m_err  = 0;

  function automatic logic is_tok(input logic [9:0] w);
    return (w == 10'h354) || (w == 10'h0AB) || (w == 10'h154) || (w == 10'h2AB);
  endfunction

  function automatic logic [1:0] tok_val(input logic [9:0] w);
    if (w == 10'h0AB) return 2'b01;
    if (w == 10'h154) return 2'b10;
    if (w == 10'h2AB) return 2'b11;
    return 2'b00;
  endfunction

  // Reference decode with whole-byte arithmetic.
  function automatic logic [7:0] ref_dec(input logic [9:0] q);
    logic [7:0] x;
    logic [7:0] t;
    x = q[9] ? (8'd255 - q[7:0]) : q[7:0];
    t = x ^ (x << 1);
    return q[8] ? t : (t ^ 8'hFE);
  endfunction

  function automatic logic ref_illegal(input logic [9:0] q);
    logic [7:0] d;
    int         n;
    logic       want_xnor;
    d = ref_dec(q);
    n = $countones(d);
    want_xnor = (n > 4) || (n == 4 && d[0] == 1'b0);
    return (q[8] == want_xnor);
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int r);
    logic [19:0] t;
    t = {w, w} << r;
    return t[19:10];
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'(($urandom_range(0, 1023)));
    while (is_tok(w)) w = 10'(($urandom_range(0, 1023)));
    return w;
  endfunction

  function automatic logic [9:0] rand_tok();
    case ($urandom_range(0, 3))
      0: return 10'h354;
      1: return 10'h0AB;
      2: return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected outputs for the word now leaving S1, assuming the channel is locked.
  task automatic model_check(input logic [9:0] w, input logic clr);
    if (is_tok(w)) begin
      m_ctrl = tok_val(w);
      chk("tok_de", 32'(de), 32'(1'b0));
      chk("tok_ctrl", 32'(ctrl), 32'(m_ctrl));
      chk("tok_data", 32'(data), 32'(8'h00));
    end else begin
      chk("dat_de", 32'(de), 32'(1'b1));
      chk("dat_ctrl", 32'(ctrl), 32'(m_ctrl));
      chk("dat_data", 32'(data), 32'(ref_dec(w)));
    end
`ifdef TMDS_ERRCNT_EN
    if (clr) m_err = 0;
    else if (!is_tok(w) && ref_illegal(w) && m_err < 65535) m_err++;
`else
    m_err = 0;
`endif
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  task automatic step(input logic [9:0] w, input logic clr);
    tmds_word = w;
    err_clr   = clr;
    @(posedge clk_pixel);
    #1;
    if (m_chk) model_check(prev_w, clr);
    prev_w = w;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  slips;
    int  last;
    int  mingap;
    int  k;
    int  rot;
    logic drop_early;

    reset = 1'b1;
    err_clr = 1'b0;
    tmds_word = 10'h354;
    repeat (3) @(posedge clk_pixel);
    #1;
    chk("rst_bitslip", 32'(bitslip), 32'(1'b0));
    chk("rst_locked", 32'(locked), 32'(1'b0));
    chk("rst_de", 32'(de), 32'(1'b0));
    chk("rst_ctrl", 32'(ctrl), 32'(2'b00));
    chk("rst_data", 32'(data), 32'(8'h00));
    chk("rst_err", 32'(err_count), 32'(16'h0000));

    // Aligned token stream: lock eight cycles after the first token enters S1.
    reset = 1'b0;
    slips = 0;
    for (int i = 1; i <= 12; i++) begin
      step(10'h354, 1'b0);
      if (bitslip) slips++;
      if (i == 8) chk("lock_early", 32'(locked), 32'(1'b0));
      if (i == 9) chk("lock_on_time", 32'(locked), 32'(1'b1));
    end
    chk("aligned_no_slip", 32'(slips), 32'd0);

    m_chk = 1'b1; m_ctrl = 2'b00; m_err = 0;
    step(10'h100, 1'b0);
    step(10'h200, 1'b0);
    chk("w100_data", 32'(data), 32'(8'h00));
    chk("w100_de", 32'(de), 32'(1'b1));
    step(10'h0AB, 1'b0);
    chk("w200_data", 32'(data), 32'(8'hFF));
    chk("w200_de", 32'(de), 32'(1'b1));
    step(10'h354, 1'b0);
    chk("w0AB_de", 32'(de), 32'(1'b0));
    chk("w0AB_ctrl", 32'(ctrl), 32'(2'b01));

    // Random locked traffic against the model (tokens keep lock alive).
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) step(rand_tok(), 1'b0);
      else step(rand_data(), 1'b0);
    end
    step(10'h354, 1'b1);
    step(10'h354, 1'b0);
    chk("err_cleared", 32'(err_count), 32'd0);

    // Illegal characters: 10'h0AA decodes to 0 via XNOR, encoder would use XOR.
    step(10'h0AA, 1'b0);
    step(10'h0AA, 1'b0);
    step(10'h0AA, 1'b0);
    step(10'h354, 1'b0);
`ifdef TMDS_ERRCNT_EN
    chk("err_three", 32'(err_count), 32'd3);
`else
    chk("err_tied", 32'(err_count), 32'd0);
`endif
    step(10'h0AA, 1'b0);
    step(10'h354, 1'b1);   // clear coincides with processing of the fourth 0AA
    chk("err_clr_wins", 32'(err_count), 32'd0);
    step(10'h354, 1'b0);

    // Reset in the middle of data.
    step(rand_data(), 1'b0);
    step(rand_data(), 1'b0);
    m_chk = 1'b0;
    reset = 1'b1;
    tmds_word = rand_data();
    @(posedge clk_pixel);
    #1;
    chk("mid_rst_locked", 32'(locked), 32'(1'b0));
    chk("mid_rst_de", 32'(de), 32'(1'b0));
    chk("mid_rst_data", 32'(data), 32'(8'h00));
    chk("mid_rst_err", 32'(err_count), 32'(16'h0000));
    reset = 1'b0;

    for (int i = 0; i < 9; i++) step(10'h354, 1'b0);
    chk("relock", 32'(locked), 32'(1'b1));

    // Loss of lock after LOSS_WINDOW data words without a token.
    m_chk = 1'b1; m_ctrl = 2'b00; m_err = 0;
    drop_early = 1'b0;
    for (int i = 1; i <= 4097; i++) begin
      step(rand_data(), 1'b0);
      if (i <= 4096 && !locked) drop_early = 1'b1;
    end
    m_chk = 1'b0;
    chk("loss_held", 32'(drop_early), 32'(1'b0));
    chk("loss_dropped", 32'(locked), 32'(1'b0));
    k = 0;
    while (k < 3000 && !bitslip) begin
      step(rand_data(), 1'b0);
      k++;
    end
    chk("slip_after_loss", 32'(k), 32'd2048);

    // Misaligned stream: deserialiser model rotates on each bitslip.
    reset = 1'b1;
    @(posedge clk_pixel);
    #1;
    reset = 1'b0;
    rot = 3; slips = 0; last = -1; mingap = 1000000; k = 0;
    while (!locked && k < 20000) begin
      step(rotl(10'h354, rot), 1'b0);
      k++;
      if (bitslip) begin
        slips++;
        if (last >= 0 && (k - last) < mingap) mingap = k - last;
        last = k;
        rot = (rot + 1) % 10;
      end
    end
    chk("slip_locked", 32'(locked), 32'(1'b1));
    chk("slip_count", 32'(slips), 32'd7);
    chk("slip_gap", 32'(mingap >= 2064), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
